// File: rtl/game_sequencer.sv
// Frame-level controller for the Flappy datapath: game FSM, per-frame physics/scroll
// strobes, four-cycle pipe collision/pass scan and saturating BCD score.
module game_sequencer #(
  parameter int unsigned BIRD_X   = 200,
  parameter int unsigned BIRD_W   = 16,
  parameter int unsigned BIRD_H   = 16,
  parameter int unsigned PIPE_W   = 40,
  parameter int unsigned GAP_H    = 100,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Frame_Tick,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Jump,
  input  logic [9:0] Bird_Y,
  input  logic [9:0] Pipe_X,
  input  logic [9:0] Pipe_Gap_Y,
  output logic [1:0] Pipe_Index,
  output logic       Game_Clear,
  output logic       Phys_Step,
  output logic       Jump_Req,
  output logic       Scroll_Step,
  output logic       Q_Initial,
  output logic       Q_Run,
  output logic       Q_Lose,
  output logic [7:0] Score,
  output logic       Frame_Overrun
);

  localparam int unsigned SW = 11;

  typedef enum logic [2:0] {
    S_INITIAL,
    S_WAIT_FRAME,
    S_PHYS,
    S_SCROLL,
    S_CHECK,
    S_DECIDE,
    S_LOSE
  } state_t;

  state_t        state;
  logic [3:0]    passed;
  logic [2:0]    pending;
  logic          hit_any;
  logic          jump_latch;

  logic [SW-1:0] pipe_l, pipe_r, bird_l, bird_r, bird_t, bird_b, gap_t, gap_b;
  logic          x_overlap, outside_gap, hit_c, pass_c, ground_c, in_frame_c;

  // Geometry in 11-bit unsigned so no sum can wrap
  assign pipe_l      = {1'b0, Pipe_X};
  assign pipe_r      = pipe_l + SW'(PIPE_W);
  assign bird_l      = SW'(BIRD_X);
  assign bird_r      = SW'(BIRD_X + BIRD_W);
  assign bird_t      = {1'b0, Bird_Y};
  assign bird_b      = bird_t + SW'(BIRD_H);
  assign gap_t       = {1'b0, Pipe_Gap_Y};
  assign gap_b       = gap_t + SW'(GAP_H);

  assign x_overlap   = (pipe_l < bird_r) && (pipe_r > bird_l);
  assign outside_gap = (bird_t < gap_t) || (bird_b > gap_b);
  assign hit_c       = x_overlap && outside_gap;
  assign pass_c      = pipe_r < bird_l;
  assign ground_c    = bird_b >= SW'(SCREEN_H);
  assign in_frame_c  = (state == S_PHYS) || (state == S_SCROLL) ||
                       (state == S_CHECK) || (state == S_DECIDE);

  // Two-digit BCD add of 0..4, clamped at 99
  function automatic logic [7:0] bcd_add(input logic [7:0] s, input logic [2:0] p);
    logic [4:0] ones;
    logic [4:0] tens;
    ones = 5'(s[3:0]) + 5'(p);
    tens = 5'(s[7:4]);
    if (ones > 5'd9) begin
      ones = ones - 5'd10;
      tens = tens + 5'd1;
    end
    if (tens > 5'd9) return 8'h99;
    return {tens[3:0], ones[3:0]};
  endfunction

  always_ff @(posedge Clk) begin
    if (reset) begin
      state         <= S_INITIAL;
      {Q_Initial, Q_Run, Q_Lose} <= 3'b100;
      Pipe_Index    <= 2'd0;
      Game_Clear    <= 1'b0;
      Phys_Step     <= 1'b0;
      Jump_Req      <= 1'b0;
      Scroll_Step   <= 1'b0;
      Score         <= 8'h00;
      Frame_Overrun <= 1'b0;
      passed        <= 4'b0;
      pending       <= 3'd0;
      hit_any       <= 1'b0;
      jump_latch    <= 1'b0;
    end else begin
      Game_Clear  <= 1'b0;
      Phys_Step   <= 1'b0;
      Jump_Req    <= 1'b0;
      Scroll_Step <= 1'b0;

      // A tick that lands while a frame is still being sequenced is dropped
      if (Frame_Tick && in_frame_c) Frame_Overrun <= 1'b1;

      case (state)
        S_INITIAL: begin
          if (Start) begin
            state         <= S_WAIT_FRAME;
            {Q_Initial, Q_Run, Q_Lose} <= 3'b010;
            Game_Clear    <= 1'b1;
            Score         <= 8'h00;
            passed        <= 4'b0;
            pending       <= 3'd0;
            jump_latch    <= 1'b0;
            Frame_Overrun <= 1'b0;
          end
        end

        S_WAIT_FRAME: begin
          if (Jump) jump_latch <= 1'b1;
          if (Frame_Tick) begin
            state     <= S_PHYS;
            Phys_Step <= 1'b1;
            Jump_Req  <= jump_latch | Jump;
          end
        end

        S_PHYS: begin
          // Latch is consumed here; a jump arriving now waits for next frame
          jump_latch  <= Jump;
          state       <= S_SCROLL;
          Scroll_Step <= 1'b1;
        end

        S_SCROLL: begin
          if (Jump) jump_latch <= 1'b1;
          state      <= S_CHECK;
          Pipe_Index <= 2'd0;
          pending    <= 3'd0;
          hit_any    <= 1'b0;
        end

        S_CHECK: begin
          if (Jump) jump_latch <= 1'b1;
          if (hit_c) hit_any <= 1'b1;
          if (pass_c) begin
            if (!passed[Pipe_Index]) begin
              passed[Pipe_Index] <= 1'b1;
              pending            <= 3'(pending + 3'd1);
            end
          end else begin
            passed[Pipe_Index] <= 1'b0;
          end
          if (Pipe_Index == 2'd3) begin
            state      <= S_DECIDE;
            Pipe_Index <= 2'd0;
          end else begin
            Pipe_Index <= 2'(Pipe_Index + 2'd1);
          end
        end

        S_DECIDE: begin
          if (Jump) jump_latch <= 1'b1;
          if (hit_any || ground_c) begin
            state <= S_LOSE;
            {Q_Initial, Q_Run, Q_Lose} <= 3'b001;
          end else begin
            state <= S_WAIT_FRAME;
            Score <= bcd_add(Score, pending);
          end
        end

        S_LOSE: begin
          if (Ack) begin
            state <= S_INITIAL;
            {Q_Initial, Q_Run, Q_Lose} <= 3'b100;
          end
        end

        default: begin
          state <= S_INITIAL;
          {Q_Initial, Q_Run, Q_Lose} <= 3'b100;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: frame-offset behavioural model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_game_sequencer;

  localparam int BX = 200, BW = 16, BH = 16, PW = 40, GH = 100, SH = 480;
  localparam int M_INIT = 0, M_RUN = 1, M_LOSE = 2;

  logic       clk;
  logic       reset, Frame_Tick, Start, Ack, Jump;
  logic [9:0] Bird_Y;
  logic [9:0] px [4];
  logic [9:0] pg [4];
  logic [9:0] Pipe_X, Pipe_Gap_Y;
  logic [1:0] Pipe_Index;
  logic       Game_Clear, Phys_Step, Jump_Req, Scroll_Step;
  logic       Q_Initial, Q_Run, Q_Lose, Frame_Overrun;
  logic [7:0] Score;

  int n_cmp = 0;
  int n_fail = 0;
  int phys_cnt = 0;

  assign Pipe_X     = px[Pipe_Index];
  assign Pipe_Gap_Y = pg[Pipe_Index];

  game_sequencer dut (
    .Clk(clk), .reset(reset), .Frame_Tick(Frame_Tick), .Start(Start), .Ack(Ack),
    .Jump(Jump), .Bird_Y(Bird_Y), .Pipe_X(Pipe_X), .Pipe_Gap_Y(Pipe_Gap_Y),
    .Pipe_Index(Pipe_Index), .Game_Clear(Game_Clear), .Phys_Step(Phys_Step),
    .Jump_Req(Jump_Req), .Scroll_Step(Scroll_Step), .Q_Initial(Q_Initial),
    .Q_Run(Q_Run), .Q_Lose(Q_Lose), .Score(Score), .Frame_Overrun(Frame_Overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: game mode plus position within the frame (0 = waiting, 1..7 = offset)
  int m_mode, m_off, m_score, m_pend;
  bit m_passed [4];
  bit m_hit, m_jl, m_ovr, m_valid;
  bit e_clear, e_phys, e_jreq, e_scroll;

  task automatic model_pipe(input int i);
    int l, r, bt, bb, gt;
    l  = int'(px[i]);
    r  = l + PW;
    gt = int'(pg[i]);
    bt = int'(Bird_Y);
    bb = bt + BH;
    if (l < BX + BW && r > BX && (bt < gt || bb > gt + GH)) m_hit = 1;
    if (r < BX) begin
      if (!m_passed[i]) begin
        m_passed[i] = 1;
        m_pend++;
      end
    end else begin
      m_passed[i] = 0;
    end
  endtask

  task automatic model_step();
    e_clear = 0; e_phys = 0; e_jreq = 0; e_scroll = 0;
    if (reset) begin
      m_mode = M_INIT; m_off = 0; m_score = 0; m_pend = 0;
      m_passed = '{default: 0};
      m_hit = 0; m_jl = 0; m_ovr = 0; m_valid = 1;
      return;
    end
    case (m_mode)
      M_INIT: if (Start) begin
        m_mode = M_RUN; m_off = 0; m_score = 0; m_pend = 0;
        m_passed = '{default: 0};
        m_jl = 0; m_ovr = 0; e_clear = 1;
      end
      M_RUN: begin
        if (m_off == 0) begin
          if (Frame_Tick) begin
            e_phys = 1; e_jreq = m_jl || Jump; m_jl = 0;
            m_off = 1; m_pend = 0; m_hit = 0;
          end else if (Jump) m_jl = 1;
        end else begin
          if (Frame_Tick) m_ovr = 1;
          if (Jump) m_jl = 1;
          if (m_off >= 3 && m_off <= 6) model_pipe(m_off - 3);
          if (m_off == 7) begin
            if (m_hit || int'(Bird_Y) + BH >= SH) m_mode = M_LOSE;
            else m_score = (m_score + m_pend > 99) ? 99 : m_score + m_pend;
            m_off = 0;
          end else begin
            m_off++;
            if (m_off == 2) e_scroll = 1;
          end
        end
      end
      default: if (Ack) m_mode = M_INIT;
    endcase
  endtask

  task automatic compare_all();
    int eidx;
    if (!m_valid) return;
    eidx = (m_mode == M_RUN && m_off >= 3 && m_off <= 6) ? m_off - 3 : 0;
    chk("Q_Initial", 8'(Q_Initial), 8'(m_mode == M_INIT));
    chk("Q_Run", 8'(Q_Run), 8'(m_mode == M_RUN));
    chk("Q_Lose", 8'(Q_Lose), 8'(m_mode == M_LOSE));
    chk("Game_Clear", 8'(Game_Clear), 8'(e_clear));
    chk("Phys_Step", 8'(Phys_Step), 8'(e_phys));
    chk("Jump_Req", 8'(Jump_Req), 8'(e_jreq));
    chk("Scroll_Step", 8'(Scroll_Step), 8'(e_scroll));
    chk("Pipe_Index", 8'(Pipe_Index), 8'(eidx));
    chk("Score", Score, {4'(m_score / 10), 4'(m_score % 10)});
    chk("Frame_Overrun", 8'(Frame_Overrun), 8'(m_ovr));
  endtask

  initial begin
    m_valid = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    compare_all();
    if (Phys_Step === 1'b1) phys_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    Start = 1; step(1); Start = 0;
  endtask

  task automatic pulse_ack();
    Ack = 1; step(1); Ack = 0;
  endtask

  // One frame: tick in cycle 0, optional Jump at a given offset, 10 cycles total
  task automatic frame(input int jump_off);
    for (int c = 0; c < 10; c++) begin
      Frame_Tick = (c == 0);
      Jump       = (c == jump_off);
      step(1);
    end
    Frame_Tick = 0;
    Jump = 0;
  endtask

  task automatic set_all_px(input logic [9:0] x);
    for (int i = 0; i < 4; i++) px[i] = x;
  endtask

  int snap;

  initial begin
    reset = 1; Frame_Tick = 0; Start = 0; Ack = 0; Jump = 0;
    Bird_Y = 10'd240;
    for (int i = 0; i < 4; i++) begin
      px[i] = 10'(600 + 100 * i);
      pg[i] = 10'd200;
    end
    step(2);
    reset = 0;
    chk("lit reset Q_Initial", 8'(Q_Initial), 8'd1);
    chk("lit reset Score", Score, 8'h00);
    step(2);

    // Start: clear pulse then idle with no steps
    pulse_start();
    chk("lit Game_Clear", 8'(Game_Clear), 8'd1);
    chk("lit Q_Run", 8'(Q_Run), 8'd1);
    step(1);
    chk("lit Game_Clear low", 8'(Game_Clear), 8'd0);
    step(5);

    // Jump before tick: strobes at cycles 1, 2, index 0..3 at 3..6
    Jump = 1; step(1); Jump = 0; step(2);
    Frame_Tick = 1; step(1); Frame_Tick = 0;
    chk("lit Phys_Step c1", 8'(Phys_Step), 8'd1);
    chk("lit Jump_Req c1", 8'(Jump_Req), 8'd1);
    step(1);
    chk("lit Scroll_Step c2", 8'(Scroll_Step), 8'd1);
    step(1);
    chk("lit Pipe_Index c3", 8'(Pipe_Index), 8'd0);
    step(3);
    chk("lit Pipe_Index c6", 8'(Pipe_Index), 8'd3);
    step(5);
    chk("lit Score frame1", Score, 8'h00);

    // Passing pipe 2
    px[2] = 10'd150;
    frame(-1);
    chk("lit Score pass", Score, 8'h01);
    frame(-1);
    chk("lit Score no double", Score, 8'h01);
    px[2] = 10'd160;   // right edge 200: neither passed nor overlapping
    frame(-1);
    chk("lit Score edge 200", Score, 8'h01);
    px[2] = 10'd159;
    frame(-1);
    chk("lit Score edge 199", Score, 8'h02);

    // Jump during PHYS is held for next frame
    frame(1);
    frame(-1);

    // Collision wins over a pending pass
    px[2] = 10'd600;
    frame(-1);
    px[2] = 10'd150;
    px[1] = 10'd190; pg[1] = 10'd300; Bird_Y = 10'd100;
    frame(-1);
    chk("lit Q_Lose collide", 8'(Q_Lose), 8'd1);
    chk("lit Score collide", Score, 8'h02);
    pulse_start();
    step(2);
    chk("lit Start ignored", 8'(Q_Lose), 8'd1);
    pulse_ack();
    chk("lit Ack", 8'(Q_Initial), 8'd1);
    step(2);

    // Ground boundary
    px[1] = 10'd700; pg[1] = 10'd200; px[2] = 10'd800;
    pulse_start();
    step(2);
    Bird_Y = 10'd463;
    frame(-1);
    chk("lit ground 463", 8'(Q_Run), 8'd1);
    Bird_Y = 10'd464;
    frame(-1);
    chk("lit ground 464", 8'(Q_Lose), 8'd1);
    pulse_ack();
    step(2);

    // Saturation at 99
    Bird_Y = 10'd240;
    pulse_start();
    step(2);
    for (int k = 0; k < 24; k++) begin
      set_all_px(10'd100); frame(-1);
      set_all_px(10'd600); frame(-1);
    end
    chk("lit Score 96", Score, 8'h96);
    px[0] = 10'd100; px[1] = 10'd100; px[2] = 10'd100;
    frame(-1);
    chk("lit Score 99", Score, 8'h99);
    set_all_px(10'd600); frame(-1);
    px[0] = 10'd100; px[1] = 10'd100;
    frame(-1);
    chk("lit Score sat", Score, 8'h99);
    set_all_px(10'd600); frame(-1);

    // Overrun: second tick 4 cycles after the first
    snap = phys_cnt;
    Frame_Tick = 1; step(1); Frame_Tick = 0;
    step(3);
    Frame_Tick = 1; step(1); Frame_Tick = 0;
    step(8);
    chk("lit Frame_Overrun", 8'(Frame_Overrun), 8'd1);
    chk("lit one Phys_Step", 8'(phys_cnt - snap), 8'd1);

    // Reset mid-frame aborts the scan
    Frame_Tick = 1; step(1); Frame_Tick = 0;
    step(3);
    reset = 1; step(1); reset = 0;
    step(4);
    chk("lit mid reset Q_Initial", 8'(Q_Initial), 8'd1);
    chk("lit mid reset Score", Score, 8'h00);
    chk("lit mid reset overrun", 8'(Frame_Overrun), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Frame-level controller for the Flappy datapath. It runs the game state machine (initial, running, lost). Once per video frame it sequences the shared datapath: a physics step, then a pipe scroll step, then a four-cycle collision/score scan over the pipe table through a single pipe index port. It sits between the debouncers, `flight_physics`, the pipe RAM/ROM pair and the SSD score display, and replaces the ad-hoc Start/Ack/Check wiring in the top level.

## Interface
Parameters:
- BIRD_X, 200, fixed bird left edge (pixels)
- BIRD_W, 16, bird width
- BIRD_H, 16, bird height
- PIPE_W, 40, pipe width
- GAP_H, 100, vertical gap height starting at Pipe_Gap_Y
- SCREEN_H, 480, ground line; the bird loses when its bottom edge reaches it

Ports:
- Clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Frame_Tick  in  1  one-cycle pulse at start of vertical blank
- Start  in  1  debounced single-cycle pulse
- Ack  in  1  debounced single-cycle pulse
- Jump  in  1  debounced single-cycle pulse
- Bird_Y  in  10  bird top edge, unsigned, from physics
- Pipe_X  in  10  left edge of pipe at Pipe_Index, combinational, valid the same cycle
- Pipe_Gap_Y  in  10  gap top of pipe at Pipe_Index, combinational
- Pipe_Index  out  2  pipe being read
- Game_Clear  out  1  one-cycle pulse that reinitialises physics and the pipe RAM
- Phys_Step  out  1  one-cycle physics advance enable
- Jump_Req  out  1  asserted only together with Phys_Step
- Scroll_Step  out  1  one-cycle pipe scroll enable
- Q_Initial, Q_Run, Q_Lose  out  1 each  one-hot state summary
- Score  out  8  two BCD digits ({tens, ones})
- Frame_Overrun  out  1  sticky flag

## Operation
- States: INITIAL, WAIT_FRAME, PHYS, SCROLL, CHECK, DECIDE, LOSE. Q_Run is high in WAIT_FRAME through DECIDE.
- INITIAL:
  - Start → WAIT_FRAME.
  - On that transition: pulse Game_Clear, clear Score, clear the passed[3:0] flags, clear the jump latch.
- WAIT_FRAME: Frame_Tick → PHYS.
- PHYS:
  - Phys_Step=1.
  - Jump_Req is the jump latch value; the latch clears in this cycle.
  - → SCROLL.
- SCROLL: Scroll_Step=1 → CHECK with Pipe_Index=0.
- CHECK:
  - One cycle per pipe. Pipe_Index steps 0,1,2,3, then → DECIDE.
  - For each index i, compute hit_i and pass_i.
- Collision for pipe i:
  - X overlap: Pipe_X < BIRD_X+BIRD_W and Pipe_X+PIPE_W > BIRD_X.
  - Outside gap: Bird_Y < Pipe_Gap_Y or Bird_Y+BIRD_H > Pipe_Gap_Y+GAP_H.
  - hit_i = X overlap AND outside gap.
  - All sums use 11-bit unsigned arithmetic; no wrap.
- Pass flags for pipe i:
  - If Pipe_X+PIPE_W < BIRD_X and passed[i]=0: set passed[i] and add one to the pending count.
  - If Pipe_X+PIPE_W ≥ BIRD_X: clear passed[i]. This re-arms a pipe that has wrapped back to the right.
- Ground check: the bird has hit the ground when Bird_Y+BIRD_H ≥ SCREEN_H. It is evaluated in DECIDE.
- DECIDE:
  - Any hit this frame, or ground → LOSE. Pending passes are discarded (collision wins).
  - Otherwise add the pending count (0–4) to Score in BCD, saturating at 99, → WAIT_FRAME.
- LOSE:
  - Score holds; no steps are issued.
  - Ack → INITIAL. Start is ignored.
- Jump latch: set by Jump in any Q_Run state; ignored in INITIAL and LOSE. A Jump in the same cycle as PHYS is held for the next frame.
- Frame_Overrun: set when Frame_Tick arrives in PHYS..DECIDE (the tick is dropped). Cleared only by reset or Game_Clear.
- Start and Ack outside their states have no effect.

## Timing
- Reset values:
  - State INITIAL, so Q_Initial=1, Q_Run=0, Q_Lose=0.
  - Score=8'h00, Pipe_Index=0, Frame_Overrun=0.
  - Game_Clear=0, Phys_Step=0, Jump_Req=0, Scroll_Step=0.
  - passed and pending count cleared.
- Reset mid-frame aborts the scan; no further strobes are issued.
- Frame sequence, with the tick sampled at cycle 0:
  - PHYS at cycle 1.
  - SCROLL at cycle 2.
  - CHECK at cycles 3–6.
  - DECIDE at cycle 7.
  - Score updates at the cycle-8 edge. WAIT_FRAME is re-entered at cycle 8.
- Minimum Frame_Tick spacing: 8 cycles.
- All outputs are registered. Pipe_Index is stable throughout each CHECK cycle.
- Bird_Y is sampled in CHECK and DECIDE. Physics must have settled by cycle 3.

## Test plan
- Reset then Start: Game_Clear pulses once, Q_Run=1. With no Frame_Tick, Phys_Step and Scroll_Step stay 0.
- Frame_Tick with a Jump pulse earlier: Phys_Step and Jump_Req both high at cycle 1. Scroll_Step high at cycle 2. Pipe_Index 0..3 at cycles 3–6.
- Pipe 2 at X=150 (right edge 190 < 200), other pipes far right, no hits: Score 00→01 after one frame. The next frame with the same X leaves Score at 01.
- Collision: Pipe_X=190, Pipe_Gap_Y=300, Bird_Y=100 → LOSE at the cycle-8 edge, with Score unchanged even if a pass is pending that frame. Ack → Q_Initial.
- Ground: Bird_Y=464, no pipe overlap → LOSE.
- Score=99 with two passes in one frame → Score stays 99. A second Frame_Tick 4 cycles after the first → Frame_Overrun=1 and only one Phys_Step is issued.
